core_io_responder: RTL and testbench

- Peripheral-side responder for the core's I/O port.
- Consumes commands the core drives on to_peripheral / to_peripheral_data / to_peripheral_valid.
- Answers on from_peripheral / from_peripheral_data / from_peripheral_valid.
- Bridges to a host through two small FIFOs:
  - rx FIFO: host to core.
  - tx FIFO: core to host.
- Sits between RISC_V_Core and a bench-side or UART-side host model.

---
 rtl/core_io_responder.sv | 191 +++++++++++++++++++
 tb/tb_core_io_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_io_responder.sv
// Peripheral-side responder for the core I/O port: answers PUT/GET/STATUS
// commands with a one-cycle registered response and bridges to host rx/tx FIFOs.
module core_io_responder #(
   parameter int DATA_WIDTH      = 32,
   parameter int FIFO_DEPTH_BITS = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [1:0]            to_peripheral,
   input  logic [DATA_WIDTH-1:0] to_peripheral_data,
   input  logic                  to_peripheral_valid,
   output logic [1:0]            from_peripheral,
   output logic [DATA_WIDTH-1:0] from_peripheral_data,
   output logic                  from_peripheral_valid,
   input  logic [DATA_WIDTH-1:0] host_rx_data,
   input  logic                  host_rx_valid,
   output logic                  host_rx_ready,
   output logic [DATA_WIDTH-1:0] host_tx_data,
   output logic                  host_tx_valid,
   input  logic                  host_tx_ready
);

   localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
   localparam logic [FIFO_DEPTH_BITS:0]   FULL_COUNT = (FIFO_DEPTH_BITS+1)'(DEPTH);
   localparam logic [FIFO_DEPTH_BITS:0]   CNT_ONE    = (FIFO_DEPTH_BITS+1)'(1);
   localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE    = FIFO_DEPTH_BITS'(1);

   localparam logic [1:0] RSP_NONE   = 2'b00;
   localparam logic [1:0] RSP_ACK    = 2'b01;
   localparam logic [1:0] RSP_NACK   = 2'b10;
   localparam logic [1:0] RSP_STATUS = 2'b11;

   typedef enum logic [1:0] {
      CMD_NONE   = 2'b00,
      CMD_PUT    = 2'b01,
      CMD_GET    = 2'b10,
      CMD_STATUS = 2'b11
   } cmd_e;

   typedef enum logic {
      ST_IDLE,
      ST_RESP
   } state_e;

   logic [DATA_WIDTH-1:0]      r_rxMem [DEPTH];
   logic [FIFO_DEPTH_BITS-1:0] r_rxWr;
   logic [FIFO_DEPTH_BITS-1:0] r_rxRd;
   logic [FIFO_DEPTH_BITS:0]   r_rxCount;

   logic [DATA_WIDTH-1:0]      r_txMem [DEPTH];
   logic [FIFO_DEPTH_BITS-1:0] r_txWr;
   logic [FIFO_DEPTH_BITS-1:0] r_txRd;
   logic [FIFO_DEPTH_BITS:0]   r_txCount;

   state_e                     r_state;

   cmd_e                       w_cmd;
   logic                       w_cmdAccept;
   logic                       w_rxEmpty;
   logic                       w_rxFull;
   logic                       w_txEmpty;
   logic                       w_txFull;
   logic                       w_rxPush;
   logic                       w_rxPop;
   logic                       w_txPush;
   logic                       w_txPop;
   logic [1:0]                 w_respCode;
   logic [DATA_WIDTH-1:0]      w_respData;
   logic [DATA_WIDTH-1:0]      w_statusWord;

   assign w_cmd       = cmd_e'(to_peripheral);
   assign w_cmdAccept = to_peripheral_valid && (w_cmd != CMD_NONE);

   assign w_rxEmpty = (r_rxCount == '0);
   assign w_rxFull  = (r_rxCount == FULL_COUNT);
   assign w_txEmpty = (r_txCount == '0);
   assign w_txFull  = (r_txCount == FULL_COUNT);

   // All full/empty decisions use pre-edge counts, so a same-edge pop never
   // frees a slot for a push and a same-edge push is never visible to a pop.
   assign w_rxPush = host_rx_valid && !w_rxFull;
   assign w_rxPop  = w_cmdAccept && (w_cmd == CMD_GET) && !w_rxEmpty;
   assign w_txPush = w_cmdAccept && (w_cmd == CMD_PUT) && !w_txFull;
   assign w_txPop  = host_tx_ready && !w_txEmpty;

   assign host_rx_ready = !w_rxFull;
   assign host_tx_valid = !w_txEmpty;
   assign host_tx_data  = w_txEmpty ? '0 : r_txMem[r_txRd];

   always_ff @(posedge clock) begin
      if (w_rxPush) begin
         r_rxMem[r_rxWr] <= host_rx_data;
      end
      if (w_txPush) begin
         r_txMem[r_txWr] <= to_peripheral_data;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_rxWr    <= '0;
         r_rxRd    <= '0;
         r_rxCount <= '0;
      end else begin
         if (w_rxPush) begin
            r_rxWr <= r_rxWr + PTR_ONE;
         end
         if (w_rxPop) begin
            r_rxRd <= r_rxRd + PTR_ONE;
         end
         if (w_rxPush && !w_rxPop) begin
            r_rxCount <= r_rxCount + CNT_ONE;
         end else if (!w_rxPush && w_rxPop) begin
            r_rxCount <= r_rxCount - CNT_ONE;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_txWr    <= '0;
         r_txRd    <= '0;
         r_txCount <= '0;
      end else begin
         if (w_txPush) begin
            r_txWr <= r_txWr + PTR_ONE;
         end
         if (w_txPop) begin
            r_txRd <= r_txRd + PTR_ONE;
         end
         if (w_txPush && !w_txPop) begin
            r_txCount <= r_txCount + CNT_ONE;
         end else if (!w_txPush && w_txPop) begin
            r_txCount <= r_txCount - CNT_ONE;
         end
      end
   end

   always_comb begin
      w_statusWord        = '0;
      w_statusWord[7:0]   = 8'(r_rxCount);
      w_statusWord[15:8]  = 8'(r_txCount);
      w_statusWord[16]    = w_rxEmpty;
      w_statusWord[17]    = w_txFull;
   end

   always_comb begin
      w_respCode = RSP_NONE;
      w_respData = '0;
      case (w_cmd)
         CMD_PUT: begin
            w_respCode = w_txFull ? RSP_NACK : RSP_ACK;
         end
         CMD_GET: begin
            if (w_rxEmpty) begin
               w_respCode = RSP_NACK;
            end else begin
               w_respCode = RSP_ACK;
               w_respData = r_rxMem[r_rxRd];
            end
         end
         CMD_STATUS: begin
            w_respCode = RSP_STATUS;
            w_respData = w_statusWord;
         end
         default: begin
            w_respCode = RSP_NONE;
         end
      endcase
   end

   // Reset has priority, which also swallows a command accepted on the reset edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state              <= ST_IDLE;
         from_peripheral      <= RSP_NONE;
         from_peripheral_data <= '0;
      end else if (w_cmdAccept) begin
         r_state              <= ST_RESP;
         from_peripheral      <= w_respCode;
         from_peripheral_data <= w_respData;
      end else begin
         r_state              <= ST_IDLE;
         from_peripheral      <= RSP_NONE;
         from_peripheral_data <= '0;
      end
   end

   assign from_peripheral_valid = (r_state == ST_RESP);

endmodule

// File: tb/tb_core_io_responder.sv
// Self-checking bench for core_io_responder: directed vector table followed by
// randomized traffic compared against a queue-based reference model.
module tb_core_io_responder;

   localparam int DEPTH = 4;

   logic        clock;
   logic        reset;
   logic [1:0]  toPeripheral;
   logic [31:0] toPeripheralData;
   logic        toPeripheralValid;
   logic [1:0]  fromPeripheral;
   logic [31:0] fromPeripheralData;
   logic        fromPeripheralValid;
   logic [31:0] hostRxData;
   logic        hostRxValid;
   logic        hostRxReady;
   logic [31:0] hostTxData;
   logic        hostTxValid;
   logic        hostTxReady;

   int checkCount = 0;
   int errorCount = 0;

   logic [31:0] rxQ[$];
   logic [31:0] txQ[$];

   typedef struct {
      logic        rst;
      logic        vld;
      logic [1:0]  cmd;
      logic [31:0] dat;
      logic        rxV;
      logic [31:0] rxD;
      logic        txR;
      logic        eV;
      logic [1:0]  eC;
      logic [31:0] eD;
      logic        eRxRdy;
      logic        eTxV;
      logic [31:0] eTxD;
   } vec_t;

   vec_t vecs[$];

   core_io_responder dut (
      .clock                 (clock),
      .reset                 (reset),
      .to_peripheral         (toPeripheral),
      .to_peripheral_data    (toPeripheralData),
      .to_peripheral_valid   (toPeripheralValid),
      .from_peripheral       (fromPeripheral),
      .from_peripheral_data  (fromPeripheralData),
      .from_peripheral_valid (fromPeripheralValid),
      .host_rx_data          (hostRxData),
      .host_rx_valid         (hostRxValid),
      .host_rx_ready         (hostRxReady),
      .host_tx_data          (hostTxData),
      .host_tx_valid         (hostTxValid),
      .host_tx_ready         (hostTxReady)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   function automatic vec_t mk(input logic rst, input logic vld, input logic [1:0] cmd,
                               input logic [31:0] dat, input logic rxV, input logic [31:0] rxD,
                               input logic txR, input logic eV, input logic [1:0] eC,
                               input logic [31:0] eD, input logic eRxRdy, input logic eTxV,
                               input logic [31:0] eTxD);
      vec_t v;
      v.rst = rst; v.vld = vld; v.cmd = cmd; v.dat = dat;
      v.rxV = rxV; v.rxD = rxD; v.txR = txR;
      v.eV = eV; v.eC = eC; v.eD = eD;
      v.eRxRdy = eRxRdy; v.eTxV = eTxV; v.eTxD = eTxD;
      return v;
   endfunction

   task automatic applyStimulus(input vec_t v);
      reset             = v.rst;
      toPeripheralValid = v.vld;
      toPeripheral      = v.cmd;
      toPeripheralData  = v.dat;
      hostRxValid       = v.rxV;
      hostRxData        = v.rxD;
      hostTxReady       = v.txR;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   initial begin
      vec_t        v;
      logic        rRst;
      logic        rVld;
      logic [1:0]  rCmd;
      logic [31:0] rDat;
      logic        rRxV;
      logic [31:0] rRxD;
      logic        rTxR;
      logic        expV;
      logic [1:0]  expC;
      logic [31:0] expD;
      int          rxCnt;
      int          txCnt;
      logic        putOk;
      logic        getOk;

      // Hold reset for three edges before anything else happens.
      applyStimulus(mk('1, '0, 2'd0, '0, '0, '0, '0, '0, 2'd0, '0, '0, '0, '0));
      repeat (3) @(posedge clock);
      #1;
      checkOutput("rst.valid",  32'(fromPeripheralValid), 32'd0);
      checkOutput("rst.code",   32'(fromPeripheral),      32'd0);
      checkOutput("rst.data",   fromPeripheralData,       32'd0);
      checkOutput("rst.rxRdy",  32'(hostRxReady),         32'd1);
      checkOutput("rst.txV",    32'(hostTxValid),         32'd0);
      checkOutput("rst.txData", hostTxData,               32'd0);

      //           rst vld cmd    dat            rxV rxD            txR  eV  eC     eD             rxRdy txV txD
      vecs.push_back(mk('0, '1, 2'd3, '0,            '0, '0,            '0, '1, 2'd3, 32'h0001_0000, '1, '0, '0));
      vecs.push_back(mk('0, '1, 2'd0, 32'h1234,      '0, '0,            '0, '0, 2'd0, '0,            '1, '0, '0));
      vecs.push_back(mk('0, '1, 2'd1, 32'hDEADBEEF,  '0, '0,            '0, '1, 2'd1, '0,            '1, '1, 32'hDEADBEEF));
      vecs.push_back(mk('0, '0, 2'd0, '0,            '0, '0,            '1, '0, 2'd0, '0,            '1, '0, '0));
      vecs.push_back(mk('0, '0, 2'd2, '0,            '1, 32'h0000_1000, '0, '0, 2'd0, '0,            '1, '0, '0));
      vecs.push_back(mk('0, '0, 2'd0, '0,            '1, 32'h8000_0000, '0, '0, 2'd0, '0,            '1, '0, '0));
      vecs.push_back(mk('0, '1, 2'd2, '0,            '0, '0,            '0, '1, 2'd1, 32'h0000_1000, '1, '0, '0));
      vecs.push_back(mk('0, '1, 2'd2, '0,            '0, '0,            '0, '1, 2'd1, 32'h8000_0000, '1, '0, '0));
      vecs.push_back(mk('0, '1, 2'd2, '0,            '0, '0,            '0, '1, 2'd2, '0,            '1, '0, '0));
      vecs.push_back(mk('0, '1, 2'd1, 32'h11,        '0, '0,            '0, '1, 2'd1, '0,            '1, '1, 32'h11));
      vecs.push_back(mk('0, '1, 2'd1, 32'h22,        '0, '0,            '0, '1, 2'd1, '0,            '1, '1, 32'h11));
      vecs.push_back(mk('0, '1, 2'd1, 32'h33,        '0, '0,            '0, '1, 2'd1, '0,            '1, '1, 32'h11));
      vecs.push_back(mk('0, '1, 2'd1, 32'h44,        '0, '0,            '0, '1, 2'd1, '0,            '1, '1, 32'h11));
      vecs.push_back(mk('0, '1, 2'd1, 32'h55,        '0, '0,            '0, '1, 2'd2, '0,            '1, '1, 32'h11));
      vecs.push_back(mk('0, '1, 2'd3, '0,            '0, '0,            '0, '1, 2'd3, 32'h0003_0400, '1, '1, 32'h11));
      vecs.push_back(mk('0, '0, 2'd0, '0,            '0, '0,            '1, '0, 2'd0, '0,            '1, '1, 32'h22));
      vecs.push_back(mk('0, '0, 2'd0, '0,            '0, '0,            '1, '0, 2'd0, '0,            '1, '1, 32'h33));
      vecs.push_back(mk('0, '0, 2'd0, '0,            '0, '0,            '1, '0, 2'd0, '0,            '1, '1, 32'h44));
      vecs.push_back(mk('0, '0, 2'd0, '0,            '0, '0,            '1, '0, 2'd0, '0,            '1, '0, '0));
      vecs.push_back(mk('0, '0, 2'd0, '0,            '1, 32'hA1,        '0, '0, 2'd0, '0,            '1, '0, '0));
      vecs.push_back(mk('0, '0, 2'd0, '0,            '1, 32'hA2,        '0, '0, 2'd0, '0,            '1, '0, '0));
      vecs.push_back(mk('0, '0, 2'd0, '0,            '1, 32'hA3,        '0, '0, 2'd0, '0,            '1, '0, '0));
      vecs.push_back(mk('0, '0, 2'd0, '0,            '1, 32'hA4,        '0, '0, 2'd0, '0,            '0, '0, '0));
      vecs.push_back(mk('0, '1, 2'd2, '0,            '1, 32'hBAD,       '0, '1, 2'd1, 32'hA1,        '1, '0, '0));
      vecs.push_back(mk('0, '1, 2'd3, '0,            '0, '0,            '0, '1, 2'd3, 32'h0000_0003, '1, '0, '0));
      vecs.push_back(mk('0, '1, 2'd2, '0,            '0, '0,            '0, '1, 2'd1, 32'hA2,        '1, '0, '0));
      vecs.push_back(mk('0, '1, 2'd2, '0,            '0, '0,            '0, '1, 2'd1, 32'hA3,        '1, '0, '0));
      vecs.push_back(mk('0, '1, 2'd2, '0,            '0, '0,            '0, '1, 2'd1, 32'hA4,        '1, '0, '0));
      vecs.push_back(mk('0, '1, 2'd2, '0,            '0, '0,            '0, '1, 2'd2, '0,            '1, '0, '0));
      vecs.push_back(mk('0, '1, 2'd1, 32'h66,        '1, 32'h5,         '0, '1, 2'd1, '0,            '1, '1, 32'h66));
      vecs.push_back(mk('1, '1, 2'd1, 32'h77,        '0, '0,            '0, '0, 2'd0, '0,            '1, '0, '0));
      vecs.push_back(mk('0, '1, 2'd3, '0,            '0, '0,            '0, '1, 2'd3, 32'h0001_0000, '1, '0, '0));

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         applyStimulus(v);
         @(posedge clock);
         #1;
         checkOutput($sformatf("vec%0d.valid", i),  32'(fromPeripheralValid), 32'(v.eV));
         checkOutput($sformatf("vec%0d.code", i),   32'(fromPeripheral),      32'(v.eC));
         checkOutput($sformatf("vec%0d.data", i),   fromPeripheralData,       v.eD);
         checkOutput($sformatf("vec%0d.rxRdy", i),  32'(hostRxReady),         32'(v.eRxRdy));
         checkOutput($sformatf("vec%0d.txV", i),    32'(hostTxValid),         32'(v.eTxV));
         checkOutput($sformatf("vec%0d.txData", i), hostTxData,               v.eTxD);
      end

      // Random traffic; the first cycle is a reset so the model starts in step.
      for (int cyc = 0; cyc < 400; cyc++) begin
         rRst = (cyc == 0) || ($urandom_range(0, 49) == 0);
         rVld = ($urandom_range(0, 99) < 70);
         rCmd = 2'($urandom_range(0, 3));
         rDat = $urandom;
         rRxV = ($urandom_range(0, 99) < 50);
         rRxD = $urandom;
         rTxR = ($urandom_range(0, 99) < 40);
         applyStimulus(mk(rRst, rVld, rCmd, rDat, rRxV, rRxD, rTxR, '0, 2'd0, '0, '0, '0, '0));

         expV  = 1'b0;
         expC  = 2'd0;
         expD  = 32'd0;
         rxCnt = rxQ.size();
         txCnt = txQ.size();
         putOk = 1'b0;
         getOk = 1'b0;
         if (rRst) begin
            rxQ.delete();
            txQ.delete();
         end else begin
            if (rVld && rCmd != 2'd0) begin
               expV = 1'b1;
               if (rCmd == 2'd1) begin
                  putOk = (txCnt < DEPTH);
                  expC  = putOk ? 2'd1 : 2'd2;
               end else if (rCmd == 2'd2) begin
                  getOk = (rxCnt > 0);
                  expC  = getOk ? 2'd1 : 2'd2;
                  expD  = getOk ? rxQ[0] : 32'd0;
               end else begin
                  expC = 2'd3;
                  expD = 32'(rxCnt + txCnt * 256 + (rxCnt == 0 ? 65536 : 0)
                             + (txCnt == DEPTH ? 131072 : 0));
               end
            end
            if (getOk) void'(rxQ.pop_front());
            if (rRxV && rxCnt < DEPTH) rxQ.push_back(rRxD);
            if (rTxR && txCnt > 0) void'(txQ.pop_front());
            if (putOk) txQ.push_back(rDat);
         end

         @(posedge clock);
         #1;
         checkOutput($sformatf("rnd%0d.valid", cyc), 32'(fromPeripheralValid), 32'(expV));
         checkOutput($sformatf("rnd%0d.code", cyc),  32'(fromPeripheral),      32'(expC));
         checkOutput($sformatf("rnd%0d.data", cyc),  fromPeripheralData,       expD);
         checkOutput($sformatf("rnd%0d.rxRdy", cyc), 32'(hostRxReady),         32'(rxQ.size() < DEPTH));
         checkOutput($sformatf("rnd%0d.txV", cyc),   32'(hostTxValid),         32'(txQ.size() > 0));
         checkOutput($sformatf("rnd%0d.txData", cyc), hostTxData,
                     (txQ.size() > 0) ? txQ[0] : 32'd0);
      end

      applyStimulus(mk('0, '0, 2'd0, '0, '0, '0, '0, '0, 2'd0, '0, '0, '0, '0));
      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule
